// File: rtl/node_mem_bridge.sv
// Per-node memory endpoint: switch read/write ports plus a lower-priority host port
// sharing one read and one write port on a local BF16 word array.
module node_mem_bridge #(
    parameter int unsigned MEM_DEPTH  = 256,
    parameter int unsigned RD_LATENCY = 2,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sw_read_valid,
    input  logic [ADDR_WIDTH-1:0] sw_read_addr,
    output logic                  sw_read_data_valid,
    output logic [DATA_WIDTH-1:0] sw_read_data,
    input  logic                  sw_write_valid,
    input  logic [ADDR_WIDTH-1:0] sw_write_addr,
    input  logic [DATA_WIDTH-1:0] sw_write_data,
    output logic                  sw_write_done,
    input  logic                  host_req_valid,
    input  logic                  host_req_we,
    input  logic [ADDR_WIDTH-1:0] host_req_addr,
    input  logic [DATA_WIDTH-1:0] host_req_wdata,
    output logic                  host_req_ready,
    output logic                  host_rdata_valid,
    output logic [DATA_WIDTH-1:0] host_rdata
);

    localparam int unsigned IDX_W = $clog2(MEM_DEPTH);
    localparam int unsigned LAST  = RD_LATENCY - 1;

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    logic                  host_acc;
    logic                  wr_en;
    logic [IDX_W-1:0]      wr_idx;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic                  rd_host;
    logic [IDX_W-1:0]      rd_idx;

    logic                  vld_q [RD_LATENCY];
    logic                  own_q [RD_LATENCY];
    logic [DATA_WIDTH-1:0] dat_q [RD_LATENCY];
    logic [DATA_WIDTH-1:0] sw_hold_q;
    logic [DATA_WIDTH-1:0] host_hold_q;
    logic                  done_q;

    assign host_req_ready = rst_n & (host_req_we ? !sw_write_valid : !sw_read_valid);
    assign host_acc       = host_req_valid & host_req_ready;

    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = '0;
        wr_data = '0;
        rd_en   = 1'b0;
        rd_host = 1'b0;
        rd_idx  = '0;
        if (rst_n) begin
            if (sw_write_valid) begin
                wr_en   = 1'b1;
                wr_idx  = sw_write_addr[IDX_W-1:0];
                wr_data = sw_write_data;
            end else if (host_acc && host_req_we) begin
                wr_en   = 1'b1;
                wr_idx  = host_req_addr[IDX_W-1:0];
                wr_data = host_req_wdata;
            end
            if (sw_read_valid) begin
                rd_en  = 1'b1;
                rd_idx = sw_read_addr[IDX_W-1:0];
            end else if (host_acc && !host_req_we) begin
                rd_en   = 1'b1;
                rd_host = 1'b1;
                rd_idx  = host_req_addr[IDX_W-1:0];
            end
        end
    end

    // Array is not reset; a same-edge read samples the pre-write contents.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < RD_LATENCY; i++) begin
                vld_q[i] <= 1'b0;
                own_q[i] <= 1'b0;
                dat_q[i] <= '0;
            end
            sw_hold_q   <= '0;
            host_hold_q <= '0;
            done_q      <= 1'b0;
        end else begin
            vld_q[0] <= rd_en;
            own_q[0] <= rd_host;
            dat_q[0] <= mem_q[rd_idx];
            for (int unsigned i = 1; i < RD_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                own_q[i] <= own_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
            if (vld_q[LAST] && !own_q[LAST]) begin
                sw_hold_q <= dat_q[LAST];
            end
            if (vld_q[LAST] && own_q[LAST]) begin
                host_hold_q <= dat_q[LAST];
            end
            done_q <= sw_write_valid;
        end
    end

    // Data outputs show the live final stage on a valid pulse, otherwise the last delivered word.
    assign sw_read_data_valid = vld_q[LAST] & !own_q[LAST];
    assign sw_read_data       = sw_read_data_valid ? dat_q[LAST] : sw_hold_q;
    assign host_rdata_valid   = vld_q[LAST] & own_q[LAST];
    assign host_rdata         = host_rdata_valid ? dat_q[LAST] : host_hold_q;
    assign sw_write_done      = done_q;

endmodule
